// File: rtl/mw_timer_pkg.sv
// Shared types and constants for the microwave timer datapath.
package mw_timer_pkg;

  localparam int unsigned BCD_W = 4;

  typedef logic [BCD_W-1:0] bcd_t;

  localparam bcd_t BCD_MAX      = 4'd9;
  localparam bcd_t SEC_TENS_MAX = 4'd5;
  localparam bcd_t ADD30_TENS   = 4'd3;

endpackage

// File: rtl/bcd_digit_dn.sv
// One BCD down-counting digit of the timer borrow chain.
//   clock, clr     : clock, async active-high clear
//   ld, ld_val     : parallel load (wins over borrow_in)
//   borrow_in      : decrement this digit this cycle
//   q              : registered digit value
//   borrow_out_c   : combinational, digit wraps and borrows from the next one
module bcd_digit_dn
  import mw_timer_pkg::*;
#(
  parameter bcd_t WRAP = BCD_MAX
) (
  input  logic clock,
  input  logic clr,
  input  logic ld,
  input  bcd_t ld_val,
  input  logic borrow_in,
  output bcd_t q,
  output logic borrow_out_c
);

  assign borrow_out_c = borrow_in && (q == '0);

  // Digit register: load, else decrement with wrap to WRAP.
  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      q <= '0;
    end else if (ld) begin
      q <= ld_val;
    end else if (borrow_in) begin
      q <= (q == '0) ? WRAP : q - 4'd1;
    end
  end

endmodule

// File: rtl/bcd_mmss_countdown.sv
// BCD minutes/seconds countdown timer with keypad shift-in and add-30s.
//   clock, clr     : clock, async active-high clear
//   load, data     : shift a BCD keypad digit in (data > 9 ignored)
//   enable         : count down while high, pause when low
//   add30          : add 30 seconds (ignored when sec_tens > 5)
//   sec_ones/tens  : seconds digits
//   mins           : minute digits, least-significant in [3:0]
//   zero           : combinational, all digits zero
//   done           : one-cycle pulse after the decrement that reaches zero
module bcd_mmss_countdown
  import mw_timer_pkg::*;
#(
  parameter int unsigned MIN_DIGITS = 1,
  parameter int unsigned TICK_DIV   = 1
) (
  input  logic                    clock,
  input  logic                    clr,
  input  logic                    load,
  input  logic [3:0]              data,
  input  logic                    enable,
  input  logic                    add30,
  output logic [3:0]              sec_ones,
  output logic [3:0]              sec_tens,
  output logic [4*MIN_DIGITS-1:0] mins,
  output logic                    zero,
  output logic                    done
);

  localparam int unsigned N_DIG = 2 + MIN_DIGITS;
  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  // Digit index 0 = sec_ones, 1 = sec_tens, 2.. = minutes (LSD first).
  bcd_t             dig_q  [N_DIG];
  bcd_t             ld_val [N_DIG];
  logic             dig_ld;
  logic [N_DIG:0]   borrow;
  logic [PRE_W-1:0] presc;
  logic             load_ok;
  logic             add_ok;
  logic             advance;
  logic             tick;
  logic             upper_zero;
  logic             add_carry;
  bcd_t             tens_sum;

  assign load_ok  = load && (data <= BCD_MAX);
  assign add_ok   = !load && add30 && (dig_q[1] <= SEC_TENS_MAX);
  // Any load/add30 request consumes the cycle, even when it is ignored.
  assign advance  = enable && !zero && !load && !add30;
  assign tick     = advance && (presc == PRE_LAST);
  assign tens_sum = dig_q[1] + ADD30_TENS;

  // Zero detection over all digits.
  always_comb begin
    upper_zero = 1'b1;
    for (int unsigned i = 1; i < N_DIG; i++) begin
      if (dig_q[i] != '0) upper_zero = 1'b0;
    end
  end

  assign zero = upper_zero && (dig_q[0] == '0);

  // Parallel load values for keypad shift and add-30 with minute carry.
  always_comb begin
    dig_ld    = 1'b0;
    add_carry = 1'b0;
    for (int unsigned i = 0; i < N_DIG; i++) ld_val[i] = dig_q[i];
    if (load_ok) begin
      dig_ld    = 1'b1;
      ld_val[0] = data;
      for (int unsigned i = 1; i < N_DIG; i++) ld_val[i] = dig_q[i-1];
    end else if (add_ok) begin
      dig_ld = 1'b1;
      if (tens_sum >= 4'd6) begin
        ld_val[1] = tens_sum - 4'd6;
        add_carry = 1'b1;
        for (int unsigned k = 2; k < N_DIG; k++) begin
          if (add_carry) begin
            if (dig_q[k] == BCD_MAX) begin
              ld_val[k] = '0;
            end else begin
              ld_val[k] = dig_q[k] + 4'd1;
              add_carry = 1'b0;
            end
          end
        end
        // Carry out of the top minute digit saturates at the maximum time.
        if (add_carry) begin
          ld_val[0] = BCD_MAX;
          ld_val[1] = SEC_TENS_MAX;
          for (int unsigned k = 2; k < N_DIG; k++) ld_val[k] = BCD_MAX;
        end
      end else begin
        ld_val[1] = tens_sum;
      end
    end
  end

  assign borrow[0] = tick;

  // Digit chain; sec_tens wraps to 5, every other digit to 9.
  for (genvar i = 0; i < N_DIG; i++) begin : g_dig
    bcd_digit_dn #(
      .WRAP((i == 1) ? SEC_TENS_MAX : BCD_MAX)
    ) u_dig (
      .clock       (clock),
      .clr         (clr),
      .ld          (dig_ld),
      .ld_val      (ld_val[i]),
      .borrow_in   (borrow[i]),
      .q           (dig_q[i]),
      .borrow_out_c(borrow[i+1])
    );
  end

  assign sec_ones = dig_q[0];
  assign sec_tens = dig_q[1];
  for (genvar k = 0; k < MIN_DIGITS; k++) begin : g_mins
    assign mins[4*k +: 4] = dig_q[k+2];
  end

  // Prescaler: restarts on load/add30, holds while paused or at zero.
  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      presc <= '0;
    end else if (load_ok || add_ok) begin
      presc <= '0;
    end else if (advance) begin
      presc <= (presc == PRE_LAST) ? '0 : presc + PRE_W'(1);
    end
  end

  // Done pulses when the decrement lands on 0:00 (value was 0:01).
  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      done <= 1'b0;
    end else begin
      done <= tick && upper_zero && (dig_q[0] == 4'd1);
    end
  end

  // A decrement is never issued at zero, so the chain can never underflow.
  assert property (@(posedge clock) disable iff (clr) !borrow[N_DIG]);

endmodule

// File: tb/tb_bcd_mmss_countdown.sv
module tb_bcd_mmss_countdown;

  localparam int MD_A = 1, TD_A = 1, MD_B = 2, TD_B = 4;

  typedef struct packed {
    int m; int tens; int ones; int presc; bit done;
  } mdl_t;

  logic clock = 1'b0, clr = 1'b0, load = 1'b0, enable = 1'b0, add30 = 1'b0;
  logic [3:0] data = 4'd0;
  logic [3:0] ones_a, tens_a, mins_a, ones_b, tens_b;
  logic [7:0] mins_b;
  logic zero_a, done_a, zero_b, done_b;

  int checks = 0;
  int errors = 0;
  mdl_t mdl [2];

  always #5 clock = ~clock;

  bcd_mmss_countdown #(.MIN_DIGITS(MD_A), .TICK_DIV(TD_A)) dut_a (
    .clock(clock), .clr(clr), .load(load), .data(data), .enable(enable), .add30(add30),
    .sec_ones(ones_a), .sec_tens(tens_a), .mins(mins_a), .zero(zero_a), .done(done_a));

  bcd_mmss_countdown #(.MIN_DIGITS(MD_B), .TICK_DIV(TD_B)) dut_b (
    .clock(clock), .clr(clr), .load(load), .data(data), .enable(enable), .add30(add30),
    .sec_ones(ones_b), .sec_tens(tens_b), .mins(mins_b), .zero(zero_b), .done(done_b));

  function automatic int pow10(int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [11:0] to_bcd(int m);
    logic [11:0] r = '0;
    int v = m;
    for (int k = 0; k < 3; k++) begin
      r[4*k +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Reference: minutes kept as a plain integer, seconds as two digits.
  function automatic mdl_t mdl_step(mdl_t s, int md, int td, bit ld, int d, bit en, bit a30);
    mdl_t n = s;
    int lim = pow10(md);
    n.done = 1'b0;
    if (ld) begin
      if (d <= 9) begin
        n.m = (s.m * 10 + s.tens) % lim; n.tens = s.ones; n.ones = d; n.presc = 0;
      end
    end else if (a30) begin
      if (s.tens <= 5) begin
        n.presc = 0;
        if (s.tens + 3 >= 6) begin
          n.tens = s.tens + 3 - 6;
          if (s.m + 1 >= lim) begin n.m = lim - 1; n.tens = 5; n.ones = 9; end
          else n.m = s.m + 1;
        end else n.tens = s.tens + 3;
      end
    end else if (en && !(s.m == 0 && s.tens == 0 && s.ones == 0)) begin
      if (s.presc == td - 1) begin
        n.presc = 0;
        if (s.ones > 0) n.ones = s.ones - 1;
        else begin
          n.ones = 9;
          if (s.tens > 0) n.tens = s.tens - 1;
          else begin n.tens = 5; n.m = s.m - 1; end
        end
        n.done = (n.m == 0 && n.tens == 0 && n.ones == 0);
      end else n.presc = s.presc + 1;
    end
    return n;
  endfunction

  task automatic cycle(input bit ld, input logic [3:0] d, input bit en, input bit a30);
    load = ld; data = d; enable = en; add30 = a30;
    mdl[0] = mdl_step(mdl[0], MD_A, TD_A, ld, int'(d), en, a30);
    mdl[1] = mdl_step(mdl[1], MD_B, TD_B, ld, int'(d), en, a30);
    @(posedge clock);
    #1;
    load = 1'b0; add30 = 1'b0;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    #2;
    mdl[0] = '0; mdl[1] = '0;
    clr = 1'b0;
  endtask

  task automatic test_reset();
    load = 0; enable = 0; add30 = 0; data = 0;
    clr = 1'b1;
    @(posedge clock); #1;
    clr = 1'b0;
    mdl[0] = '0; mdl[1] = '0;
    checks++; if ({mins_a, tens_a, ones_a} !== 12'h000) begin errors++; $display("FAIL reset_digits_a got %h exp 000", {mins_a, tens_a, ones_a}); end
    checks++; if ({zero_a, done_a, zero_b, done_b} !== 4'b1010) begin errors++; $display("FAIL reset_flags got %b exp 1010", {zero_a, done_a, zero_b, done_b}); end
    cycle(1, 4'd1, 0, 0); cycle(1, 4'd3, 0, 0); cycle(1, 4'd0, 0, 0);
    checks++; if ({mins_a, tens_a, ones_a} !== 12'h130) begin errors++; $display("FAIL load_130 got %h exp 130", {mins_a, tens_a, ones_a}); end
    checks++; if (zero_a !== 1'b0) begin errors++; $display("FAIL load_zero got %b exp 0", zero_a); end
  endtask

  task automatic test_countdown();
    do_clr();
    cycle(1, 4'd0, 0, 0); cycle(1, 4'd2, 0, 0);
    cycle(0, 4'd0, 1, 0);
    checks++; if ({mins_a, tens_a, ones_a, done_a} !== {12'h001, 1'b0}) begin errors++; $display("FAIL count_001 got %h/%b exp 001/0", {mins_a, tens_a, ones_a}, done_a); end
    cycle(0, 4'd0, 1, 0);
    checks++; if ({mins_a, tens_a, ones_a} !== 12'h000) begin errors++; $display("FAIL count_000 got %h exp 000", {mins_a, tens_a, ones_a}); end
    checks++; if ({zero_a, done_a} !== 2'b11) begin errors++; $display("FAIL count_done got %b exp 11", {zero_a, done_a}); end
    for (int i = 0; i < 5; i++) begin
      cycle(0, 4'd0, 1, 0);
      checks++; if ({zero_a, done_a, mins_a, tens_a, ones_a} !== {2'b10, 12'h000}) begin errors++; $display("FAIL hold_zero[%0d] got %b/%h exp 10/000", i, {zero_a, done_a}, {mins_a, tens_a, ones_a}); end
    end
  endtask

  task automatic test_borrow();
    do_clr();
    cycle(1, 4'd1, 0, 0); cycle(1, 4'd0, 0, 0); cycle(1, 4'd0, 0, 0); cycle(1, 4'd0, 0, 0);
    checks++; if ({mins_b, tens_b, ones_b} !== 16'h1000) begin errors++; $display("FAIL borrow_load got %h exp 1000", {mins_b, tens_b, ones_b}); end
    for (int i = 0; i < 3; i++) cycle(0, 4'd0, 1, 0);
    checks++; if ({mins_b, tens_b, ones_b} !== 16'h1000) begin errors++; $display("FAIL borrow_early got %h exp 1000", {mins_b, tens_b, ones_b}); end
    cycle(0, 4'd0, 1, 0);
    checks++; if ({mins_b, tens_b, ones_b} !== 16'h0959) begin errors++; $display("FAIL borrow_0959 got %h exp 0959", {mins_b, tens_b, ones_b}); end
    do_clr();
    cycle(1, 4'd9, 0, 0); cycle(1, 4'd0, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 4'd0, 1, 0);
    checks++; if ({mins_b, tens_b, ones_b} !== 16'h0089) begin errors++; $display("FAIL borrow_0089 got %h exp 0089", {mins_b, tens_b, ones_b}); end
  endtask

  task automatic test_pause();
    do_clr();
    cycle(1, 4'd0, 0, 0); cycle(1, 4'd5, 0, 0);
    cycle(0, 4'd0, 1, 0); cycle(0, 4'd0, 1, 0);
    cycle(0, 4'd0, 0, 0); cycle(0, 4'd0, 0, 0); cycle(0, 4'd0, 0, 0);
    checks++; if (ones_b !== 4'd5) begin errors++; $display("FAIL pause_hold got %0d exp 5", ones_b); end
    cycle(0, 4'd0, 1, 0);
    checks++; if (ones_b !== 4'd5) begin errors++; $display("FAIL pause_resume1 got %0d exp 5", ones_b); end
    cycle(0, 4'd0, 1, 0);
    checks++; if (ones_b !== 4'd4) begin errors++; $display("FAIL pause_resume2 got %0d exp 4", ones_b); end
  endtask

  task automatic test_add30();
    do_clr();
    cycle(1, 4'd4, 0, 0); cycle(1, 4'd5, 0, 0); cycle(0, 4'd0, 0, 1);
    checks++; if ({mins_a, tens_a, ones_a} !== 12'h115) begin errors++; $display("FAIL add30_045 got %h exp 115", {mins_a, tens_a, ones_a}); end
    do_clr();
    cycle(1, 4'd9, 0, 0); cycle(1, 4'd5, 0, 0); cycle(1, 4'd9, 0, 0); cycle(0, 4'd0, 0, 1);
    checks++; if ({mins_a, tens_a, ones_a} !== 12'h959) begin errors++; $display("FAIL add30_sat got %h exp 959", {mins_a, tens_a, ones_a}); end
    do_clr();
    cycle(1, 4'd7, 0, 0); cycle(1, 4'd0, 0, 0); cycle(0, 4'd0, 0, 1);
    checks++; if ({mins_a, tens_a, ones_a} !== 12'h070) begin errors++; $display("FAIL add30_070 got %h exp 070", {mins_a, tens_a, ones_a}); end
    do_clr();
    cycle(0, 4'd0, 1, 1);
    checks++; if ({mins_a, tens_a, ones_a, done_a} !== {12'h030, 1'b0}) begin errors++; $display("FAIL add30_zero_a got %h/%b exp 030/0", {mins_a, tens_a, ones_a}, done_a); end
    checks++; if ({mins_b, tens_b, ones_b, done_b} !== {16'h0030, 1'b0}) begin errors++; $display("FAIL add30_zero_b got %h/%b exp 0030/0", {mins_b, tens_b, ones_b}, done_b); end
  endtask

  task automatic test_priority();
    do_clr();
    cycle(1, 4'd1, 0, 0); cycle(1, 4'd2, 0, 0); cycle(1, 4'd3, 0, 1);
    checks++; if ({mins_a, tens_a, ones_a} !== 12'h123) begin errors++; $display("FAIL prio_load_add got %h exp 123", {mins_a, tens_a, ones_a}); end
    cycle(1, 4'hA, 1, 0);
    checks++; if ({mins_a, tens_a, ones_a} !== 12'h123) begin errors++; $display("FAIL prio_bad_data got %h exp 123", {mins_a, tens_a, ones_a}); end
    cycle(0, 4'd0, 1, 0);
    checks++; if ({mins_a, tens_a, ones_a} !== 12'h122) begin errors++; $display("FAIL prio_tick got %h exp 122", {mins_a, tens_a, ones_a}); end
    clr = 1'b1;
    #2;
    checks++; if ({mins_a, tens_a, ones_a, zero_a, zero_b} !== {12'h000, 2'b11}) begin errors++; $display("FAIL clr_async got %h/%b exp 000/11", {mins_a, tens_a, ones_a}, {zero_a, zero_b}); end
    clr = 1'b0;
    mdl[0] = '0; mdl[1] = '0;
    cycle(0, 4'd0, 1, 0);
    checks++; if ({mins_a, tens_a, ones_a, done_a} !== {12'h000, 1'b0}) begin errors++; $display("FAIL clr_stay got %h/%b exp 000/0", {mins_a, tens_a, ones_a}, done_a); end
  endtask

  task automatic test_random();
    logic [11:0] em;
    do_clr();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) do_clr();
      cycle($urandom_range(0, 4) == 0, 4'($urandom_range(0, 11)),
            $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0);
      em = to_bcd(mdl[0].m);
      checks++; if ({mins_a, tens_a, ones_a, done_a} !== {em[3:0], 4'(mdl[0].tens), 4'(mdl[0].ones), mdl[0].done})
        begin errors++; $display("FAIL rand_a[%0d] got %h/%b exp %h%h%h/%b", n, {mins_a, tens_a, ones_a}, done_a, em[3:0], 4'(mdl[0].tens), 4'(mdl[0].ones), mdl[0].done); end
      checks++; if (zero_a !== (mdl[0].m == 0 && mdl[0].tens == 0 && mdl[0].ones == 0))
        begin errors++; $display("FAIL rand_zero_a[%0d] got %b", n, zero_a); end
      em = to_bcd(mdl[1].m);
      checks++; if ({mins_b, tens_b, ones_b, done_b} !== {em[7:0], 4'(mdl[1].tens), 4'(mdl[1].ones), mdl[1].done})
        begin errors++; $display("FAIL rand_b[%0d] got %h/%b exp %h%h%h/%b", n, {mins_b, tens_b, ones_b}, done_b, em[7:0], 4'(mdl[1].tens), 4'(mdl[1].ones), mdl[1].done); end
      checks++; if (zero_b !== (mdl[1].m == 0 && mdl[1].tens == 0 && mdl[1].ones == 0))
        begin errors++; $display("FAIL rand_zero_b[%0d] got %b", n, zero_b); end
    end
  endtask

  initial begin
    mdl[0] = '0; mdl[1] = '0;
    test_reset();
    test_countdown();
    test_borrow();
    test_pause();
    test_add30();
    test_priority();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
